// File: rtl/pad_scan_if.sv
// Event handshake between the pad scanner and the downstream game/sound logic.
// The scanner drives the head event; the consumer drives ready.
interface pad_scan_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_pad;
  logic       evt_press;

  modport master (output evt_valid, output evt_pad, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_pad, input evt_press, output evt_ready);
endinterface

// File: rtl/pad_scan_ctrl.sv
// Launchpad scanner: walks the 4-to-16 pad decoder, debounces each pad on its
// once-per-scan sample, and queues press/release events in a small FIFO.
module pad_scan_ctrl #(
  parameter int SLOT_CYCLES = 8,
  parameter int DEB_SCANS   = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  output logic [3:0]  sel,
  input  logic        key_sense,
  output logic [15:0] key_state,
  output logic        scan_done,
  pad_scan_if.master  evt,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int CW = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_SCANS - 1);

  typedef struct packed {
    logic [3:0] pad;
    logic       press;
  } evt_t;

  logic [SW-1:0] slot_cnt;
  logic [CW-1:0] deb_cnt [16];
  evt_t          mem [FIFO_DEPTH];
  evt_t          head;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          sample;
  logic          differs;
  logic          push;
  logic          pop;
  logic          accept;
  logic          full;
  logic          empty;

  assign sample  = scan_en && (slot_cnt == SLOT_LAST);
  assign differs = (key_sense != key_state[sel]);
  assign push    = sample && differs && (deb_cnt[sel] == DEB_LAST);

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = !empty && evt.evt_ready;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      sel       <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= sample && (sel == 4'd15);
      if (!scan_en) begin
        slot_cnt <= '0;
      end else if (sample) begin
        slot_cnt <= '0;
        sel      <= sel + 4'd1;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state <= '0;
      for (int i = 0; i < 16; i++) deb_cnt[i] <= '0;
    end else if (sample) begin
      if (!differs) begin
        deb_cnt[sel] <= '0;
      end else if (deb_cnt[sel] == DEB_LAST) begin
        key_state[sel] <= key_sense;
        deb_cnt[sel]   <= '0;
      end else begin
        deb_cnt[sel] <= deb_cnt[sel] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the head outputs are masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= '{pad: sel, press: key_sense};
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign evt.evt_valid = !empty;
  assign evt.evt_pad   = empty ? 4'd0 : head.pad;
  assign evt.evt_press = empty ? 1'b0 : head.press;

endmodule
